// File: rtl/mul_ctrl.sv
// mul_ctrl: sequences one multiply op at a time between the execute stage,
// an external multiplier and the writeback port.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   ex_valid/ex_ready       op handshake; op, src1, src2, rd latched on accept
//   flush                   cancel whatever is in flight, back to IDLE
//   wb_valid/wb_ready       result handshake; wb_data, wb_rd held in DONE
//   m_in_valid/m_out_ready  issue handshake toward the multiplier
//   m_flush                 one-cycle cancel pulse toward the multiplier
//   m_mulw, m_signed        operand interpretation for the multiplier
//   m_multiplicand/_multiplier  operands, held from ISSUE until WAIT exits
//   m_out_valid, m_result_hi/lo  single-cycle result pulse from multiplier
//   err                     sticky multiplier-timeout flag
//
// state | meaning
// IDLE  | ready for a new op
// ISSUE | offering operands to the multiplier
// WAIT  | multiplier busy, timeout counter running
// DONE  | result held on the writeback port

module mul_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [2:0]  op,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic [4:0]  rd,
  input  logic        flush,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [63:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        m_in_valid,
  output logic        m_flush,
  output logic        m_mulw,
  output logic [1:0]  m_signed,
  output logic [63:0] m_multiplicand,
  output logic [63:0] m_multiplier,
  input  logic        m_out_ready,
  input  logic        m_out_valid,
  input  logic [63:0] m_result_hi,
  input  logic [63:0] m_result_lo,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [5:0] WAIT_LAST = 6'd39;

  state_t      r_state;
  logic [2:0]  r_op;
  logic [4:0]  r_rd;
  logic [63:0] r_mcand;
  logic [63:0] r_mplier;
  logic [1:0]  r_signed;
  logic        r_mulw;
  logic        r_m_flush;
  logic [63:0] r_wb_data;
  logic [4:0]  r_wb_rd;
  logic        r_err;
  logic [5:0]  r_wait_cnt;

  logic        w_reserved;
  logic        w_bypass;
  logic [1:0]  w_signed;
  logic        w_mulw;
  logic [63:0] w_mcand;
  logic [63:0] w_mplier;
  logic [63:0] w_result;

  assign w_reserved = op[2] & (op[1:0] != 2'b00);
  // A zero operand or reserved op has a known result of 0; skip the multiplier.
  assign w_bypass   = (src1 == 64'd0) | (src2 == 64'd0) | w_reserved;

  always_comb begin
    w_signed = 2'b11;
    w_mulw   = 1'b0;
    w_mcand  = src1;
    w_mplier = src2;
    case (op)
      3'b010: w_signed = 2'b10;
      3'b011: w_signed = 2'b00;
      3'b100: begin
        w_mulw   = 1'b1;
        w_mcand  = {{32{src1[31]}}, src1[31:0]};
        w_mplier = {{32{src2[31]}}, src2[31:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_result = 64'd0;
    case (r_op)
      3'b000:                 w_result = m_result_lo;
      3'b001, 3'b010, 3'b011: w_result = m_result_hi;
      3'b100:                 w_result = {{32{m_result_lo[31]}}, m_result_lo[31:0]};
      default:                w_result = 64'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= 3'd0;
      r_rd       <= 5'd0;
      r_mcand    <= 64'd0;
      r_mplier   <= 64'd0;
      r_signed   <= 2'b00;
      r_mulw     <= 1'b0;
      r_m_flush  <= 1'b0;
      r_wb_data  <= 64'd0;
      r_wb_rd    <= 5'd0;
      r_err      <= 1'b0;
      r_wait_cnt <= 6'd0;
    end else begin
      r_m_flush <= 1'b0;
      if (flush) begin
        // Only an op the multiplier may have seen needs cancelling there.
        r_m_flush <= (r_state == S_ISSUE) || (r_state == S_WAIT);
        r_state   <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (ex_valid) begin
              r_op <= op;
              r_rd <= rd;
              if (w_bypass) begin
                r_wb_data <= 64'd0;
                r_wb_rd   <= rd;
                r_state   <= S_DONE;
              end else begin
                r_mcand  <= w_mcand;
                r_mplier <= w_mplier;
                r_signed <= w_signed;
                r_mulw   <= w_mulw;
                r_state  <= S_ISSUE;
              end
            end
          end
          S_ISSUE: begin
            if (m_out_ready) begin
              r_wait_cnt <= 6'd0;
              r_state    <= S_WAIT;
            end
          end
          S_WAIT: begin
            // A result on the last allowed cycle still wins over the timeout.
            if (m_out_valid) begin
              r_wb_data <= w_result;
              r_wb_rd   <= r_rd;
              r_state   <= S_DONE;
            end else if (r_wait_cnt == WAIT_LAST) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_wait_cnt <= r_wait_cnt + 6'd1;
            end
          end
          S_DONE: begin
            if (wb_ready) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ex_ready       = (r_state == S_IDLE);
  assign m_in_valid     = (r_state == S_ISSUE);
  assign wb_valid       = (r_state == S_DONE);
  assign wb_data        = r_wb_data;
  assign wb_rd          = r_wb_rd;
  assign m_flush        = r_m_flush;
  assign m_mulw         = r_mulw;
  assign m_signed       = r_signed;
  assign m_multiplicand = r_mcand;
  assign m_multiplier   = r_mplier;
  assign err            = r_err;

endmodule

// File: tb/tb_mul_ctrl.sv
module tb_mul_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [2:0]  op = 3'd0;
  logic [63:0] src1 = 64'd0;
  logic [63:0] src2 = 64'd0;
  logic [4:0]  rd = 5'd0;
  logic        flush = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        m_in_valid;
  logic        m_flush;
  logic        m_mulw;
  logic [1:0]  m_signed;
  logic [63:0] m_multiplicand;
  logic [63:0] m_multiplier;
  logic        m_out_ready = 1'b0;
  logic        m_out_valid = 1'b0;
  logic [63:0] m_result_hi = 64'd0;
  logic [63:0] m_result_lo = 64'd0;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

  mul_ctrl dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .op(op), .src1(src1), .src2(src2), .rd(rd),
    .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .m_in_valid(m_in_valid), .m_flush(m_flush), .m_mulw(m_mulw), .m_signed(m_signed),
    .m_multiplicand(m_multiplicand), .m_multiplier(m_multiplier),
    .m_out_ready(m_out_ready), .m_out_valid(m_out_valid),
    .m_result_hi(m_result_hi), .m_result_lo(m_result_lo),
    .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model (op semantics) ----------------
  function automatic logic [63:0] sext32(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  function automatic logic is_bypass(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    return (a == 64'd0) || (b == 64'd0) || (o > 3'd4);
  endfunction

  function automatic logic [1:0] exp_signed(input logic [2:0] o);
    if (o == 3'd2) return 2'b10;
    if (o == 3'd3) return 2'b00;
    return 2'b11;
  endfunction

  function automatic logic [63:0] exp_opnd(input logic [2:0] o, input logic [63:0] v);
    return (o == 3'd4) ? sext32(v) : v;
  endfunction

  // Full 128-bit product with each operand read as signed or unsigned per op.
  function automatic logic [127:0] ref_prod(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [63:0]  a2, b2;
    logic [127:0] ea, eb;
    a2 = exp_opnd(o, a);
    b2 = exp_opnd(o, b);
    ea = (o == 3'd3) ? {64'd0, a2} : {{64{a2[63]}}, a2};
    eb = (o == 3'd2 || o == 3'd3) ? {64'd0, b2} : {{64{b2[63]}}, b2};
    return ea * eb;
  endfunction

  function automatic logic [63:0] exp_wb(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    if (is_bypass(o, a, b)) return 64'd0;
    p = ref_prod(o, a, b);
    case (o)
      3'd0:    return p[63:0];
      3'd4:    return sext32(p[63:0]);
      default: return p[127:64];
    endcase
  endfunction

  // ---------------- transaction helpers ----------------
  task automatic run_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] d, input int rdy_stall, input int res_dly, input int wb_stall);
    logic [127:0] p;
    logic [63:0]  ew;
    ew = exp_wb(o, a, b);
    chk("idle_ex_ready", ex_ready, 1);
    ex_valid = 1'b1; op = o; src1 = a; src2 = b; rd = d;
    tick;
    ex_valid = 1'b0; src1 = ~a; src2 = ~b; rd = ~d;
    if (is_bypass(o, a, b)) begin
      chk("byp_wb_valid", wb_valid, 1);
      chk("byp_m_in_valid", m_in_valid, 0);
    end else begin
      chk("issue_m_in_valid", m_in_valid, 1);
      chk("issue_m_signed", m_signed, exp_signed(o));
      chk("issue_m_mulw", m_mulw, o == 3'd4);
      chk("issue_mcand", m_multiplicand, exp_opnd(o, a));
      chk("issue_mplier", m_multiplier, exp_opnd(o, b));
      repeat (rdy_stall) tick;
      if (rdy_stall > 0) chk("issue_hold", m_in_valid, 1);
      m_out_ready = 1'b1;
      tick;
      m_out_ready = 1'b0;
      chk("wait_m_in_valid", m_in_valid, 0);
      repeat (res_dly) tick;
      chk("wait_no_wb", wb_valid, 0);
      chk("wait_mcand_stable", m_multiplicand, exp_opnd(o, a));
      chk("wait_mplier_stable", m_multiplier, exp_opnd(o, b));
      chk("wait_signed_stable", m_signed, exp_signed(o));
      p = ref_prod(o, a, b);
      m_result_hi = p[127:64];
      m_result_lo = p[63:0];
      m_out_valid = 1'b1;
      tick;
      m_out_valid = 1'b0;
      m_result_hi = {$urandom, $urandom};
      m_result_lo = {$urandom, $urandom};
      chk("mul_wb_valid", wb_valid, 1);
    end
    chk("wb_data", wb_data, ew);
    chk("wb_rd", wb_rd, d);
    chk("done_ex_ready", ex_ready, 0);
    repeat (wb_stall) tick;
    if (wb_stall > 0) begin
      chk("stall_wb_valid", wb_valid, 1);
      chk("stall_wb_data", wb_data, ew);
      chk("stall_wb_rd", wb_rd, d);
      chk("stall_ex_ready", ex_ready, 0);
    end
    wb_ready = 1'b1;
    tick;
    wb_ready = 1'b0;
    chk("post_wb_valid", wb_valid, 0);
    chk("post_ex_ready", ex_ready, 1);
  endtask

  task automatic start_to_wait(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    ex_valid = 1'b1; op = o; src1 = a; src2 = b; rd = 5'd9;
    tick;
    ex_valid = 1'b0;
    m_out_ready = 1'b1;
    tick;
    m_out_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]  ro;
    logic [63:0] ra, rb;

    tick; tick;
    reset = 1'b0;
    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_m_in_valid", m_in_valid, 0);
    chk("rst_m_flush", m_flush, 0);
    chk("rst_m_mulw", m_mulw, 0);
    chk("rst_m_signed", m_signed, 0);
    chk("rst_mcand", m_multiplicand, 0);
    chk("rst_mplier", m_multiplier, 0);
    chk("rst_err", err, 0);

    // Directed corner cases
    run_op(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd17, 0, 2, 0);
    run_op(3'd4, 64'h0000_0000_8000_0000, 64'd2, 5'd3, 1, 0, 0);
    run_op(3'd4, 64'h0000_0000_4000_0000, 64'd2, 5'd4, 0, 1, 0);
    run_op(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 2, 3, 1);
    run_op(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 0, 0, 0);
    run_op(3'd0, 64'h1234_5678_9ABC_DEF0, 64'd0, 5'd7, 0, 0, 5);
    run_op(3'd6, 64'd5, 64'd7, 5'd8, 0, 0, 0);
    run_op(3'd0, 64'h8000_0000_0000_0001, 64'h0000_0000_0000_0003, 5'd31, 0, 4, 2);

    // Flush in WAIT, then a late result must be ignored
    start_to_wait(3'd0, 64'd3, 64'd5);
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flw_m_flush", m_flush, 1);
    chk("flw_ex_ready", ex_ready, 1);
    chk("flw_wb_valid", wb_valid, 0);
    m_result_lo = 64'd15; m_out_valid = 1'b1;
    tick;
    m_out_valid = 1'b0;
    chk("flw_m_flush_pulse", m_flush, 0);
    chk("flw_late_wb_valid", wb_valid, 0);
    chk("flw_late_ex_ready", ex_ready, 1);

    // Flush in ISSUE
    ex_valid = 1'b1; op = 3'd1; src1 = 64'd9; src2 = 64'd9; rd = 5'd1;
    tick;
    ex_valid = 1'b0;
    flush = 1'b1; m_out_ready = 1'b1;
    tick;
    flush = 1'b0; m_out_ready = 1'b0;
    chk("fli_m_flush", m_flush, 1);
    chk("fli_m_in_valid", m_in_valid, 0);
    chk("fli_ex_ready", ex_ready, 1);

    // Flush colliding with capture in WAIT
    start_to_wait(3'd0, 64'd2, 64'd2);
    flush = 1'b1; m_out_valid = 1'b1; m_result_lo = 64'd4;
    tick;
    flush = 1'b0; m_out_valid = 1'b0;
    chk("flc_wb_valid", wb_valid, 0);
    chk("flc_m_flush", m_flush, 1);
    chk("flc_ex_ready", ex_ready, 1);

    // Flush in DONE drops the result without m_flush
    ex_valid = 1'b1; op = 3'd0; src1 = 64'd0; src2 = 64'd1; rd = 5'd2;
    tick;
    ex_valid = 1'b0;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("fld_wb_valid", wb_valid, 0);
    chk("fld_m_flush", m_flush, 0);
    chk("fld_ex_ready", ex_ready, 1);

    // Flush beats accept in IDLE
    ex_valid = 1'b1; op = 3'd0; src1 = 64'd0; src2 = 64'd0; flush = 1'b1;
    tick;
    ex_valid = 1'b0; flush = 1'b0;
    chk("fla_wb_valid", wb_valid, 0);
    chk("fla_m_in_valid", m_in_valid, 0);
    chk("fla_ex_ready", ex_ready, 1);

    // Silent multiplier: timeout after 40 WAIT cycles
    start_to_wait(3'd3, 64'd11, 64'd13);
    repeat (39) tick;
    chk("to_err_early", err, 0);
    chk("to_busy_early", ex_ready, 0);
    tick;
    chk("to_err", err, 1);
    chk("to_idle", ex_ready, 1);
    chk("to_wb_valid", wb_valid, 0);

    // err is sticky but does not block further work
    run_op(3'd0, 64'd6, 64'd7, 5'd12, 0, 1, 0);
    chk("err_sticky", err, 1);

    // Reset mid-op: no m_flush, and a later result is ignored
    start_to_wait(3'd1, 64'd21, 64'd22);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rmo_m_flush", m_flush, 0);
    chk("rmo_ex_ready", ex_ready, 1);
    chk("rmo_err", err, 0);
    chk("rmo_m_signed", m_signed, 0);
    chk("rmo_mcand", m_multiplicand, 0);
    m_out_valid = 1'b1; m_result_hi = 64'd1;
    tick;
    m_out_valid = 1'b0;
    chk("rmo_late_wb_valid", wb_valid, 0);
    chk("rmo_late_ex_ready", ex_ready, 1);

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) ra = 64'd0;
      if ($urandom_range(0, 7) == 0) rb = 64'd0;
      if ($urandom_range(0, 5) == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
      if ($urandom_range(0, 5) == 0) rb = {32'd0, 1'b1, 31'($urandom)};
      run_op(ro, ra, rb, 5'($urandom_range(0, 31)), $urandom_range(0, 2),
             $urandom_range(0, 6), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_ctrl.md
MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 SHALL have port: clock  in  1  rising-edge clock.
REQ-002 SHALL have port: reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: ex_valid in 1 op offered; ex_ready out 1 op accepted when ex_valid&ex_ready.
REQ-004 SHALL have ports: op in 3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 MULW, 101-111 reserved); src1 in 64; src2 in 64; rd in 5.
REQ-005 SHALL have port: flush  in  1  cancel in-flight op.
REQ-006 SHALL have ports: wb_valid out 1; wb_ready in 1; wb_data out 64; wb_rd out 5.
REQ-007 SHALL have multiplier-side ports: m_in_valid out 1; m_flush out 1; m_mulw out 1; m_signed out 2; m_multiplicand out 64; m_multiplier out 64.
REQ-008 SHALL have multiplier-side ports: m_out_ready in 1; m_out_valid in 1; m_result_hi in 64; m_result_lo in 64.
REQ-009 SHALL have port: err  out  1  sticky multiplier-timeout flag.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-011 SHALL drive ex_ready=1 only in IDLE; on accept, latch op, src1, src2, rd.
REQ-012 SHALL, on accept with src1==0 or src2==0 or reserved op, go IDLE->DONE with result 0, never driving m_in_valid.
REQ-013 SHALL otherwise go IDLE->ISSUE on accept.
REQ-014 SHALL in ISSUE drive m_in_valid=1; on m_in_valid&m_out_ready go WAIT next cycle; m_in_valid SHALL be 0 in every other state.
REQ-015 SHALL hold m_multiplicand/m_multiplier/m_signed/m_mulw stable from ISSUE entry until leaving WAIT.
REQ-016 SHALL map operands: MUL/MULH signed=11, multiplicand=src1, multiplier=src2; MULHSU signed=10; MULHU signed=00; MULW signed=11, mulw=1, both operands = sign-extended low 32 bits.
REQ-017 SHALL in WAIT capture m_result_hi/lo on the cycle m_out_valid=1 (single-cycle pulse) and go DONE.
REQ-018 SHALL select wb_data: MUL lo; MULH/MULHSU/MULHU hi; MULW sext(lo[31:0]).
REQ-019 SHALL in DONE assert wb_valid with registered wb_data/wb_rd stable until wb_valid&wb_ready, then go IDLE.
REQ-020 SHALL give latency accept->wb_valid of 1 cycle for bypass ops, and 1 cycle after m_out_valid for multiplied ops.
REQ-021 SHALL on flush in any state go IDLE next cycle, discard op and any result; flush has priority over accept, handshake and capture in the same cycle.
REQ-022 SHALL pulse m_flush=1 for one cycle when flush arrives in ISSUE or WAIT; 0 otherwise.
REQ-023 SHALL, after a flush in WAIT, ignore any m_out_valid arriving while in IDLE.
REQ-024 SHALL count WAIT cycles in a 6-bit counter cleared on WAIT entry; on reaching 40 without m_out_valid, set err and go IDLE.
REQ-025 SHALL hold err set until reset; err SHALL not block further ops.
REQ-026 SHALL drive wb_valid=0 in every state except DONE.

Reset
REQ-027 SHALL on reset enter IDLE: ex_ready=1, wb_valid=0, wb_data=0, wb_rd=0, m_in_valid=0, m_flush=0, m_mulw=0, m_signed=00, operands=0, err=0, counter=0.
REQ-028 SHALL, on reset mid-operation, abandon the op without m_flush and ignore subsequent m_out_valid until a new accept.

Verification
REQ-029 SHALL cover MULH src1=0xFFFF_FFFF_FFFF_FFFF, src2=2 -> m_signed=11, wb_data=0xFFFF_FFFF_FFFF_FFFF, wb_rd echoed.
REQ-030 SHALL cover MULW src1=0x0000_0000_8000_0000, src2=2 -> m_mulw=1, wb_data=0x0000_0000_0000_0000; MULW src1=0x4000_0000, src2=2 -> wb_data=0xFFFF_FFFF_8000_0000.
REQ-031 SHALL cover MULHU src1=src2=0xFFFF_FFFF_FFFF_FFFF -> m_signed=00, wb_data=0xFFFF_FFFF_FFFF_FFFE; MULHSU src1=-1, src2=0xFFFF_FFFF_FFFF_FFFF -> m_signed=10, wb_data=0xFFFF_FFFF_FFFF_FFFF.
REQ-032 SHALL cover MUL src2=0 -> wb_valid one cycle after accept, wb_data=0, m_in_valid never high.
REQ-033 SHALL cover flush in WAIT -> m_flush pulse 1 cycle, IDLE next cycle, late m_out_valid ignored, wb_valid stays 0.
REQ-034 SHALL cover wb_ready held 0 for 5 cycles in DONE -> wb_valid/wb_data stable, ex_ready=0; plus multiplier silent 40 WAIT cycles -> err=1, IDLE.
